rob_commit_queue: RTL and testbench
===================================

Name: rob_commit_queue

Overview:
- Parametrised reorder buffer for the I2OI core: in-order allocate at Issue, out-of-order completion from execute/load-store writeback ports, in-order retire to the ARF / finished store buffer at Commit.
- Sits between Issue (allocation), the NUM_WB writeback ports, and Commit.
- Generalises the single-cycle writeback path to DEPTH in-flight instructions with tags, multi-port completion, flush and retire backpressure.

Parameters:
- DEPTH, 8, entry count; power of two, at least 2.
- DATA_W, 32, result width.
- REG_W, 5, architectural register index width.
- NUM_WB, 2, number of writeback ports.
- TAG_W, $clog2(DEPTH), entry tag width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  active-low asynchronous reset
- flush  in  1  discard all entries (branch redirect)
- alloc_valid  in  1  Issue requests an entry
- alloc_ready  out  1  entry available (!full)
- alloc_rd  in  REG_W  destination register
- alloc_regwrite  in  1  instruction writes rd
- alloc_store  in  1  instruction is a store
- alloc_tag  out  TAG_W  tag granted (equals tail pointer)
- wb_valid  in  NUM_WB  per-port completion strobe
- wb_tag  in  NUM_WB*TAG_W  per-port tag; port i at [i*TAG_W +: TAG_W]
- wb_data  in  NUM_WB*DATA_W  per-port result, same packing
- commit_valid  out  1  head entry complete
- commit_ready  in  1  consumer accepts the retire
- commit_rd  out  REG_W  head rd
- commit_regwrite  out  1  head regwrite; already qualified by commit_valid
- commit_store  out  1  head is a store
- commit_data  out  DATA_W  head result
- count  out  TAG_W+1  occupied entries

Behaviour:
- Reset is asynchronous and active-low on rst, with a single clock clk. While rst=0:
  - head, tail and count are 0;
  - every entry has valid=0 and done=0;
  - commit_valid=0, alloc_ready=1, alloc_tag=0, count=0.
- Storage and pointers:
  - Each entry holds {valid, done, regwrite, store, rd, data}.
  - head and tail are TAG_W+1 bits; the top bit is the wrap bit.
  - empty is head==tail. full is when the indices match and the wrap bits differ. count is tail-head, modulo 2^(TAG_W+1).
- Allocate:
  - An allocation fires when alloc_valid && alloc_ready.
  - At the clock edge, entry[tail] becomes {valid=1, done=0, fields}, then tail increments.
  - alloc_tag is combinational from tail.
  - alloc_ready depends only on registered full. When full, there is no same-cycle bypass from a retire.
- Writeback:
  - For each port i with wb_valid[i] where entry[wb_tag].valid=1, the entry gets done=1 and data=wb_data.
  - Writeback to an invalid entry is ignored.
  - If two ports hit the same tag in one cycle, the lowest port index wins.
  - Writeback to the entry being allocated in the same cycle is ignored; allocation wins.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, combinational from registered state. A writeback to the head therefore becomes visible one cycle later (min complete-to-retire latency 1).
  - A retire fires when commit_valid && commit_ready. At the edge, entry[head].valid is cleared and head increments.
  - commit_* outputs hold steady while commit_valid=1 and commit_ready=0.
  - When commit_valid=0, the data outputs are don't-care except commit_regwrite and commit_store, which are forced to 0.
- Simultaneous events:
  - Allocate and retire in the same cycle: count is unchanged and both pointers advance.
  - Allocate into an empty ROB: the entry is not complete. commit_valid stays 0 until a writeback, then rises the following cycle.
  - Pointer wrap-around is handled by the natural overflow of the TAG_W+1-bit pointers.
- Flush:
  - Synchronous, highest priority.
  - At the edge, all valid and done bits clear, head=tail=0 and count=0.
  - An allocation, writeback or retire presented in the flush cycle has no effect.
  - Consumers must ignore commit_valid during a flush cycle.
- Reset mid-operation: asserting rst asynchronously discards all entries, same as the reset state.
- Latencies: allocate-to-visible 1 cycle; complete-to-commit_valid 1 cycle; retire throughput 1 per cycle.

Decomposition:
- Shared package i2oi_pkg holds:
  - the rob_entry_t struct {valid, done, regwrite, store, rd, data};
  - DATA_W_DEF=32 and REG_W_DEF=5.
- Sub-module rob_wb_arbiter: combinational per-entry priority select over the NUM_WB ports, producing hit and data for each entry index.
- Pointer and count logic stay in the top module.

Test Plan:
- Reset, then allocate 3 entries (rd=2, 4, 6; regwrite=1) -> alloc_tag 0, 1, 2; count=3; commit_valid=0.
- Writeback in reverse order: tag 2 data 0x22, then tag 1 data 0x11, then tag 0 data 0x5, with commit_ready=1 -> no retire until tag 0 completes. Retires then appear one per cycle in order: (rd2, 0x5), (rd4, 0x11), (rd6, 0x22).
- Fill to DEPTH=8 -> alloc_ready=0, count=8, a 9th alloc_valid is ignored. Retire one with a concurrent alloc_valid -> no allocation that cycle; alloc_ready=1 and alloc_tag=0 (after wrap) the next cycle.
- Both wb ports target tag 3 in one cycle (port0 0xAA, port1 0xBB) -> entry 3 data 0xAA.
- Head complete with commit_ready=0 for 4 cycles -> commit_* stable and count unchanged. Then flush=1 together with alloc_valid -> count=0, commit_valid=0, next alloc_tag=0.
- Pull rst low for a half-cycle mid-stream with 5 entries in flight -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/i2oi_pkg.sv
// Shared definitions for the I2OI core: default datapath widths and the
// reorder-buffer entry layout seen by tools and debug views at those widths.
package i2oi_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    // One reorder-buffer slot at the default core widths.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  regwrite;
        logic                  store;
        logic [REG_W_DEF-1:0]  rd;
        logic [DATA_W_DEF-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_wb_arbiter.sv
// Per-entry writeback selection: for every ROB index, reports whether any
// writeback port targets it this cycle and which result to take. When more
// than one port names the same tag, the lowest-numbered port wins.
module rob_wb_arbiter
    import i2oi_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_WB = 2,
    parameter int TAG_W  = $clog2(DEPTH)
) (
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    output logic [DEPTH-1:0]         hit,
    output logic [DEPTH*DATA_W-1:0]  hit_data
);

    logic match_s;

    // Scan ports from highest to lowest so the lowest index is written last and wins.
    always_comb begin
        hit      = '0;
        hit_data = '0;
        match_s  = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int i = NUM_WB - 1; i >= 0; i--) begin
                match_s = wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == TAG_W'(e));
                hit[e]  = hit[e] | match_s;
                hit_data[e*DATA_W +: DATA_W] = match_s ? wb_data[i*DATA_W +: DATA_W]
                                                       : hit_data[e*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocation at Issue, out-of-order completion over
// NUM_WB writeback ports, in-order retirement at Commit. Pointers carry one
// extra wrap bit so full/empty and occupancy fall out of plain subtraction.
module rob_commit_queue
    import i2oi_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  REG_W  = REG_W_DEF,
    parameter int  NUM_WB = 2,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [REG_W-1:0]         alloc_rd,
    input  logic                     alloc_regwrite,
    input  logic                     alloc_store,
    output logic [TAG_W-1:0]         alloc_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*DATA_W-1:0] wb_data,
    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [REG_W-1:0]         commit_rd,
    output logic                     commit_regwrite,
    output logic                     commit_store,
    output logic [DATA_W-1:0]        commit_data,
    output logic [TAG_W:0]           count
);

    // Slot layout follows rob_entry_t but tracks this instance's widths.
    typedef struct packed {
        logic              valid;
        logic              done;
        logic              regwrite;
        logic              store;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_slot_t;

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    rob_slot_t              entry_r [DEPTH];
    logic [TAG_W:0]         head_r;
    logic [TAG_W:0]         tail_r;

    logic [TAG_W-1:0]       head_idx_s;
    logic [TAG_W-1:0]       tail_idx_s;
    logic                   full_s;
    logic                   alloc_fire_s;
    logic                   retire_fire_s;
    logic                   commit_valid_s;
    rob_slot_t              head_entry_s;
    logic [DEPTH-1:0]       wb_hit_s;
    logic [DEPTH*DATA_W-1:0] wb_sel_data_s;

    rob_wb_arbiter #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .NUM_WB (NUM_WB),
        .TAG_W  (TAG_W)
    ) u_wb_arbiter (
        .wb_valid (wb_valid),
        .wb_tag   (wb_tag),
        .wb_data  (wb_data),
        .hit      (wb_hit_s),
        .hit_data (wb_sel_data_s)
    );

    assign head_idx_s = head_r[TAG_W-1:0];
    assign tail_idx_s = tail_r[TAG_W-1:0];

    // Same slot index with opposite wrap bits means every slot is occupied.
    assign full_s = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);

    // Readiness uses registered fullness only: a retire does not free a slot
    // for allocation until the following cycle.
    assign alloc_ready   = ~full_s;
    assign alloc_tag     = tail_idx_s;
    assign alloc_fire_s  = alloc_valid & ~full_s;

    assign head_entry_s   = entry_r[head_idx_s];
    assign commit_valid_s = head_entry_s.valid & head_entry_s.done;
    assign retire_fire_s  = commit_valid_s & commit_ready;

    assign commit_valid    = commit_valid_s;
    assign commit_rd       = head_entry_s.rd;
    assign commit_data     = head_entry_s.data;
    assign commit_regwrite = commit_valid_s & head_entry_s.regwrite;
    assign commit_store    = commit_valid_s & head_entry_s.store;

    assign count = tail_r - head_r;

    // Head/tail pointers: flush returns both to zero, otherwise each advances on its own fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= '0;
            tail_r <= '0;
        end else if (flush) begin
            head_r <= '0;
            tail_r <= '0;
        end else begin
            if (alloc_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (retire_fire_s) begin
                head_r <= head_r + PTR_ONE;
            end
        end
    end

    // Entry storage: writeback marks live entries done, retire frees the head,
    // allocation claims the tail slot and overrides any writeback aimed at it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                entry_r[e] <= '0;
            end
        end else if (flush) begin
            for (int e = 0; e < DEPTH; e++) begin
                entry_r[e].valid <= 1'b0;
                entry_r[e].done  <= 1'b0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wb_hit_s[e] && entry_r[e].valid &&
                    !(alloc_fire_s && (tail_idx_s == TAG_W'(e)))) begin
                    entry_r[e].done <= 1'b1;
                    entry_r[e].data <= wb_sel_data_s[e*DATA_W +: DATA_W];
                end
            end
            if (retire_fire_s) begin
                entry_r[head_idx_s].valid <= 1'b0;
                entry_r[head_idx_s].done  <= 1'b0;
            end
            if (alloc_fire_s) begin
                entry_r[tail_idx_s] <= '{valid:    1'b1,
                                         done:     1'b0,
                                         regwrite: alloc_regwrite,
                                         store:    alloc_store,
                                         rd:       alloc_rd,
                                         data:     '0};
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue (DEPTH=8, DATA_W=32, REG_W=5, NUM_WB=2).
// Inputs change 1 time unit after the rising edge; outputs are checked in
// the same window, well away from the next active edge.
module tb_rob_commit_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int NUM_WB = 2;
    localparam int TAG_W  = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     flush;
    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [REG_W-1:0]         alloc_rd;
    logic                     alloc_regwrite;
    logic                     alloc_store;
    logic [TAG_W-1:0]         alloc_tag;
    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic                     commit_valid;
    logic                     commit_ready;
    logic [REG_W-1:0]         commit_rd;
    logic                     commit_regwrite;
    logic                     commit_store;
    logic [DATA_W-1:0]        commit_data;
    logic [TAG_W:0]           count;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    rob_commit_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .NUM_WB (NUM_WB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_rd        (alloc_rd),
        .alloc_regwrite  (alloc_regwrite),
        .alloc_store     (alloc_store),
        .alloc_tag       (alloc_tag),
        .wb_valid        (wb_valid),
        .wb_tag          (wb_tag),
        .wb_data         (wb_data),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_rd       (commit_rd),
        .commit_regwrite (commit_regwrite),
        .commit_store    (commit_store),
        .commit_data     (commit_data),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_commit(input string tag, input int rd, input logic [31:0] data,
                                input logic rw, input logic st);
        check_val({tag, "_valid"}, 32'(commit_valid), 32'd1);
        check_val({tag, "_rd"}, 32'(commit_rd), 32'(rd));
        check_val({tag, "_data"}, commit_data, data);
        check_val({tag, "_regwrite"}, 32'(commit_regwrite), 32'(rw));
        check_val({tag, "_store"}, 32'(commit_store), 32'(st));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wb_set(input int port, input int tag, input logic [31:0] d);
        logic [TAG_W-1:0] t;
        t = tag[TAG_W-1:0];
        wb_valid[port] = 1'b1;
        wb_tag[port*TAG_W +: TAG_W] = t;
        wb_data[port*DATA_W +: DATA_W] = d;
    endtask

    task automatic alloc_set(input int rd, input logic rw, input logic st);
        alloc_valid    = 1'b1;
        alloc_rd       = rd[REG_W-1:0];
        alloc_regwrite = rw;
        alloc_store    = st;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
        alloc_regwrite = 1'b0; alloc_store = 1'b0; wb_valid = '0; wb_tag = '0;
        wb_data = '0; commit_ready = 1'b0;
        #3;
        check_val("rst_commit_valid", 32'(commit_valid), 32'd0);
        check_val("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check_val("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_commit_regwrite", 32'(commit_regwrite), 32'd0);
        tick; tick;
        rst = 1'b1;

        // Three allocations: rd 2, 4, 6
        for (int k = 0; k < 3; k++) begin
            alloc_set(2 + 2 * k, 1'b1, 1'b0);
            check_val("alloc_tag_seq", 32'(alloc_tag), 32'(k));
            tick;
        end
        alloc_valid = 1'b0;
        check_val("three_count", 32'(count), 32'd3);
        check_val("three_cv", 32'(commit_valid), 32'd0);

        // Reverse-order completion, in-order retirement
        commit_ready = 1'b1;
        wb_set(0, 2, 32'h22); tick; wb_valid = '0;
        check_val("wb2_cv", 32'(commit_valid), 32'd0);
        wb_set(1, 1, 32'h11); tick; wb_valid = '0;
        check_val("wb1_cv", 32'(commit_valid), 32'd0);
        check_val("wb1_count", 32'(count), 32'd3);
        wb_set(0, 0, 32'h5);
        check_val("wb0_same_cycle_cv", 32'(commit_valid), 32'd0);
        tick; wb_valid = '0;
        check_commit("ret0", 2, 32'h5, 1'b1, 1'b0);
        tick;
        check_commit("ret1", 4, 32'h11, 1'b1, 1'b0);
        tick;
        check_commit("ret2", 6, 32'h22, 1'b1, 1'b0);
        tick;
        check_val("drain_cv", 32'(commit_valid), 32'd0);
        check_val("drain_count", 32'(count), 32'd0);
        check_val("drain_regwrite", 32'(commit_regwrite), 32'd0);
        commit_ready = 1'b0;

        // Writeback to an empty slot is dropped; the later allocation is not done
        wb_set(0, 3, 32'hDEAD); tick; wb_valid = '0;
        alloc_set(7, 1'b1, 1'b0);
        check_val("wrap_alloc_tag", 32'(alloc_tag), 32'd3);
        tick; alloc_valid = 1'b0;
        check_val("stale_wb_cv", 32'(commit_valid), 32'd0);
        check_val("stale_wb_count", 32'(count), 32'd1);
        flush = 1'b1; tick; flush = 1'b0;
        check_val("flush1_count", 32'(count), 32'd0);
        check_val("flush1_tag", 32'(alloc_tag), 32'd0);

        // Fill all eight slots; entry 2 is a store without regwrite
        for (int k = 0; k < DEPTH; k++) begin
            alloc_set(8 + k, (k != 2), (k == 2));
            tick;
        end
        alloc_set(31, 1'b1, 1'b0);
        check_val("full_ready", 32'(alloc_ready), 32'd0);
        check_val("full_count", 32'(count), 32'd8);
        tick;
        check_val("ninth_count", 32'(count), 32'd8);
        check_val("ninth_ready", 32'(alloc_ready), 32'd0);

        // Retire one while alloc_valid is still held: no bypass into the freed slot
        wb_set(1, 0, 32'h100); tick; wb_valid = '0;
        check_commit("full_head", 8, 32'h100, 1'b1, 1'b0);
        commit_ready = 1'b1;
        check_val("retire_full_ready", 32'(alloc_ready), 32'd0);
        tick;
        commit_ready = 1'b0; alloc_valid = 1'b0;
        check_val("after_ret_ready", 32'(alloc_ready), 32'd1);
        check_val("after_ret_tag", 32'(alloc_tag), 32'd0);
        check_val("after_ret_count", 32'(count), 32'd7);

        // Two ports on one tag: port 0 wins
        wb_set(0, 1, 32'h101); wb_set(1, 2, 32'h102); tick;
        wb_set(0, 3, 32'hAA);  wb_set(1, 3, 32'hBB);  tick;
        wb_valid = '0;
        commit_ready = 1'b1;
        alloc_set(20, 1'b1, 1'b0);
        check_val("ret_alloc_tag", 32'(alloc_tag), 32'd0);
        check_commit("ret_t1", 9, 32'h101, 1'b1, 1'b0);
        tick; alloc_valid = 1'b0;
        check_val("ret_alloc_count", 32'(count), 32'd7);
        check_commit("ret_t2_store", 10, 32'h102, 1'b0, 1'b1);
        tick;
        check_commit("ret_t3_dual", 11, 32'hAA, 1'b1, 1'b0);
        tick;
        check_val("t4_pending_cv", 32'(commit_valid), 32'd0);
        check_val("t4_pending_count", 32'(count), 32'd5);
        commit_ready = 1'b0;

        // Backpressure: head stays stable while commit_ready is low
        wb_set(0, 4, 32'h44); tick; wb_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check_commit("stall", 12, 32'h44, 1'b1, 1'b0);
            check_val("stall_count", 32'(count), 32'd5);
            tick;
        end

        // Flush overrides a concurrent allocate, writeback and retire
        flush = 1'b1; commit_ready = 1'b1;
        alloc_set(25, 1'b1, 1'b0);
        wb_set(0, 5, 32'h55);
        tick;
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = '0; commit_ready = 1'b0;
        check_val("flush2_count", 32'(count), 32'd0);
        check_val("flush2_cv", 32'(commit_valid), 32'd0);
        check_val("flush2_tag", 32'(alloc_tag), 32'd0);
        check_val("flush2_ready", 32'(alloc_ready), 32'd1);

        // Five in flight, then an asynchronous reset pulse inside the high phase
        for (int k = 0; k < 5; k++) begin
            alloc_set(k + 1, 1'b1, 1'b0);
            tick;
        end
        alloc_valid = 1'b0;
        wb_set(0, 0, 32'h77); tick; wb_valid = '0;
        check_val("pre_rst_cv", 32'(commit_valid), 32'd1);
        check_val("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b0;
        #2;
        check_val("async_rst_count", 32'(count), 32'd0);
        check_val("async_rst_cv", 32'(commit_valid), 32'd0);
        check_val("async_rst_ready", 32'(alloc_ready), 32'd1);
        check_val("async_rst_tag", 32'(alloc_tag), 32'd0);
        check_val("async_rst_regwrite", 32'(commit_regwrite), 32'd0);
        #1;
        rst = 1'b1;
        tick;
        check_val("post_rst_count", 32'(count), 32'd0);
        check_val("post_rst_cv", 32'(commit_valid), 32'd0);
        alloc_set(9, 1'b1, 1'b0);
        check_val("post_rst_tag", 32'(alloc_tag), 32'd0);
        tick; alloc_valid = 1'b0;
        check_val("post_rst_alloc_count", 32'(count), 32'd1);
        check_val("post_rst_alloc_cv", 32'(commit_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
